ce_serializer: RTL and testbench

- Parallel-to-serial framed transmitter that consumes the single-cycle clock-enable strobe from the bit-rate enable generator.
- Accepts data words through a valid/ready handshake into a one-entry holding buffer.
- Shifts each word out LSB-first, one bit per enable strobe, with a start bit, optional even parity and stop bit(s).
- Drives the serial line toward the PHY output pad.

---
 rtl/ce_serializer.sv | 149 ++++++++++++++
 tb/tb_ce_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ce_serializer.sv
// Framed parallel-to-serial transmitter advanced by a bit-rate clock-enable strobe.
// One-entry holding buffer, LSB-first data, optional even parity, 1 or 2 stop bits.
module ce_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          PARITY_EN  = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH);
    localparam logic [CntW-1:0] StopLast = CntW'(STOP_BITS);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  buf_full_q, buf_full_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic accept, data_last, stop_last, frame_end, load;

    assign accept    = in_valid & ~buf_full_q;
    assign data_last = (cnt_q == DataLast);
    assign stop_last = (cnt_q == StopLast);
    assign frame_end = ce & (state_q == StStop) & stop_last;
    // A buffered word starts either from idle or directly after the last stop bit.
    assign load      = buf_full_q & ((ce & (state_q == StIdle)) | frame_end);

    assign in_ready = ~buf_full_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ce) begin
            unique case (state_q)
                StIdle:   if (buf_full_q) state_d = StStart;
                StStart:  state_d = StData;
                StData:   if (data_last) state_d = PARITY_EN ? StParity : StStop;
                StParity: state_d = StStop;
                StStop:   if (stop_last) state_d = buf_full_q ? StStart : StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        shift_d    = shift_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        buf_full_d = buf_full_q;
        par_d      = par_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = frame_end;

        if (accept) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end

        if (load) begin
            shift_d    = buf_q;
            par_d      = ^buf_q;
            cnt_d      = '0;
            buf_full_d = 1'b0;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
        end else if (ce) begin
            unique case (state_q)
                StStart: begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = CntW'(1);
                end
                StData: begin
                    if (data_last) begin
                        tx_d  = PARITY_EN ? par_q : 1'b1;
                        cnt_d = CntW'(1);
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    tx_d  = 1'b1;
                    cnt_d = CntW'(1);
                end
                StStop: begin
                    tx_d = 1'b1;
                    if (stop_last) begin
                        busy_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            buf_full_q <= buf_full_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_ce_serializer.sv
// Directed bench for ce_serializer: three instances (defaults, even parity, two stop bits)
// share clock, reset, ce and data; each frame is compared bit by bit against a hand-built frame.
module tb_ce_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_valid = 3'b000;

    logic tx0, tx1, tx2, busy0, busy1, busy2, rdy0, rdy1, rdy2, done0, done1, done2;
    logic [2:0] tx_v, busy_v, rdy_v, done_v;

    assign tx_v   = {tx2, tx1, tx0};
    assign busy_v = {busy2, busy1, busy0};
    assign rdy_v  = {rdy2, rdy1, rdy0};
    assign done_v = {done2, done1, done0};

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ce_serializer u_def (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_data(in_data), .in_valid(in_valid[0]),
        .in_ready(rdy0), .tx(tx0), .busy(busy0), .tx_done(done0)
    );

    ce_serializer #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .STOP_BITS(1)) u_par (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_data(in_data), .in_valid(in_valid[1]),
        .in_ready(rdy1), .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    ce_serializer #(.DATA_WIDTH(8), .PARITY_EN(1'b0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_data(in_data), .in_valid(in_valid[2]),
        .in_ready(rdy2), .tx(tx2), .busy(busy2), .tx_done(done2)
    );

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         nbits;
        logic [11:0] bits;   // bit i = i-th line bit, start bit first
        int         gmode;   // 0: ce every 4 clk, 1: gaps 3/7/1, 2: ce held high
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gap_of(input int mode, input int i);
        if (mode == 0) return 4;
        if (mode == 2) return 1;
        case (i % 3)
            0:       return 3;
            1:       return 7;
            default: return 1;
        endcase
    endfunction

    // Entered and left at a falling edge; tx must not move while ce is low.
    task automatic ce_pulse(input int gap, input logic hold, input int sel);
        for (int k = 1; k < gap; k++) begin
            @(negedge clk);
            check("hold", tx_v[sel], hold);
        end
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
    endtask

    task automatic accept_word(input int sel, input logic [7:0] d);
        check("rdy_before_accept", rdy_v[sel], 1'b1);
        in_data = d;
        in_valid[sel] = 1'b1;
        @(negedge clk);
        in_valid[sel] = 1'b0;
        check("rdy_after_accept", rdy_v[sel], 1'b0);
    endtask

    task automatic run_frame(input vec_t v);
        logic prev;
        accept_word(v.sel, v.data);
        check("wait_ce_busy", busy_v[v.sel], 1'b0);
        check("wait_ce_tx", tx_v[v.sel], 1'b1);
        prev = 1'b1;
        for (int i = 0; i < v.nbits; i++) begin
            ce_pulse(gap_of(v.gmode, i), prev, v.sel);
            check("line_bit", tx_v[v.sel], v.bits[i]);
            check("busy_in_frame", busy_v[v.sel], 1'b1);
            check("done_in_frame", done_v[v.sel], 1'b0);
            if (i == 0) check("rdy_on_load", rdy_v[v.sel], 1'b1);
            prev = v.bits[i];
        end
        ce_pulse(gap_of(v.gmode, v.nbits), prev, v.sel);
        check("done_pulse", done_v[v.sel], 1'b1);
        check("busy_end", busy_v[v.sel], 1'b0);
        check("tx_end_idle", tx_v[v.sel], 1'b1);
        @(negedge clk);
        check("done_clear", done_v[v.sel], 1'b0);
    endtask

    initial begin
        logic [19:0] b2b;
        logic [9:0]  fr;
        logic        prev;

        vecs[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, 0};
        vecs[1] = '{0, 8'h3C, 10, {2'b00, 1'b1, 8'h3C, 1'b0}, 2};
        vecs[2] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 0};
        vecs[3] = '{1, 8'hA5, 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 0};
        vecs[4] = '{2, 8'hFF, 11, {1'b0, 2'b11, 8'hFF, 1'b0}, 1};
        vecs[5] = '{1, 8'h80, 11, {1'b0, 1'b1, 1'b1, 8'h80, 1'b0}, 2};

        // Reset and idle
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("rst_tx", tx_v[s], 1'b1);
            check("rst_busy", busy_v[s], 1'b0);
            check("rst_rdy", rdy_v[s], 1'b1);
            check("rst_done", done_v[s], 1'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            ce = (k % 4 == 3);
            @(negedge clk);
            ce = 1'b0;
            check("idle_tx", tx0, 1'b1);
            check("idle_busy", busy0, 1'b0);
            check("idle_rdy", rdy0, 1'b1);
            check("idle_done", done0, 1'b0);
        end

        // Table-driven single frames
        for (int n = 0; n < 6; n++) run_frame(vecs[n]);

        // Back-to-back: second word accepted mid-DATA, no idle gap between frames
        b2b = {1'b1, 8'h80, 1'b0, 1'b1, 8'h01, 1'b0};
        accept_word(0, 8'h01);
        prev = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) accept_word(0, 8'h80);
            ce_pulse(4, prev, 0);
            check("b2b_bit", tx0, b2b[i]);
            check("b2b_busy", busy0, 1'b1);
            check("b2b_done", done0, (i == 10));
            check("b2b_rdy", rdy0, (i < 3 || i >= 10));
            prev = b2b[i];
        end
        ce_pulse(4, prev, 0);
        check("b2b_done_last", done0, 1'b1);
        check("b2b_busy_end", busy0, 1'b0);
        @(negedge clk);

        // Reset during data bit 3 with a second word buffered
        fr = {1'b1, 8'hA5, 1'b0};
        accept_word(0, 8'hA5);
        ce_pulse(4, 1'b1, 0);
        check("mr_start", tx0, 1'b0);
        accept_word(0, 8'h3C);
        prev = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ce_pulse(4, prev, 0);
            check("mr_bit", tx0, fr[i]);
            prev = fr[i];
        end
        #2 rst_n = 1'b0;
        #1;
        check("mr_async_tx", tx0, 1'b1);
        check("mr_async_busy", busy0, 1'b0);
        check("mr_async_rdy", rdy0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ce_pulse(4, 1'b1, 0);
            check("mr_no_resume_tx", tx0, 1'b1);
            check("mr_no_resume_busy", busy0, 1'b0);
            check("mr_no_resume_done", done0, 1'b0);
        end
        check("mr_buf_empty", rdy0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
